decode_scoreboard: RTL and testbench
====================================

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, meaning maximum in-flight register writes (legal range 1..31).
REQ-002 clock  input  1  meaning single rising-edge clock for all state.
REQ-003 reset  input  1  meaning synchronous, active-high reset.
REQ-004 dec_valid  input  1  meaning a decoded instruction is present in decode.
REQ-005 reg_S1, reg_S2, reg_D  input  5 each  meaning source and destination register numbers from the read-register decoder.
REQ-006 uses_s1, uses_s2, writes_d  input  1 each  meaning the instruction reads S1, reads S2, or writes D.
REQ-007 flush  input  1  meaning kill the instruction in decode this cycle.
REQ-008 wb_valid  input  1, wb_reg  input  5  meaning a writeback retires register wb_reg this cycle.
REQ-009 stall  output  1  meaning decode must hold (combinational).
REQ-010 issue  output  1  meaning the instruction leaves decode this cycle (combinational).
REQ-011 pending  output  32  meaning per-register outstanding-write bits.
REQ-012 outstanding  output  5  meaning count of set pending bits.
REQ-013 wb_err  output  1  meaning sticky flag for writeback to a non-pending register.
REQ-014 stall_cycles  output  16  meaning saturating count of stalled cycles.

Function
REQ-015 src1_haz = uses_s1 & reg_S1!=0 & pending[reg_S1]; src2_haz is the same using S2.
REQ-016 waw_haz = writes_d & reg_D!=0 & pending[reg_D].
REQ-017 full_haz = writes_d & reg_D!=0 & outstanding==MAX_OUTSTANDING.
REQ-018 stall = dec_valid & ~flush & (src1_haz | src2_haz | waw_haz | full_haz).
REQ-019 issue = dec_valid & ~flush & ~stall.
REQ-020 Register 0 is never set pending, and never causes a hazard.
REQ-021 Set on next edge: issue & writes_d & reg_D!=0 sets pending[reg_D].
REQ-022 Clear on next edge: wb_valid & wb_reg!=0 & pending[wb_reg] clears pending[wb_reg].
REQ-023 Set and clear of the same register in one cycle leaves the bit set (the new writer wins); outstanding is unchanged.
REQ-024 Set and clear of different registers in one cycle leaves outstanding unchanged.
REQ-025 Otherwise outstanding is +1 on a set and -1 on a clear.
REQ-026 outstanding always equals the popcount of pending.
REQ-027 wb_valid with wb_reg!=0 and pending[wb_reg]==0 sets wb_err.
REQ-028 wb_err holds until reset; pending and outstanding are unaffected.
REQ-029 wb_valid with wb_reg==0 is ignored entirely.
REQ-030 stall_cycles increments on each cycle stall==1 and saturates at 16'hFFFF.
REQ-031 flush forces issue=0 and stall=0, and sets no pending bit; writeback processing continues normally.
REQ-032 Latency: a bit set at edge N is visible to hazard checks from cycle N onward; a clear at edge N releases a stall in cycle N (no bypass) or earlier per REQ-037.

Reset
REQ-033 reset has priority over all inputs at the clock edge.
REQ-034 reset clears pending=0, outstanding=0, wb_err=0, stall_cycles=0.
REQ-035 During reset, stall and issue follow REQ-018/019 from the cleared state.
REQ-036 Reset asserted mid-operation discards all in-flight tracking; later writebacks to those registers set wb_err.

Configuration
REQ-037 With macro SCOREBOARD_WB_BYPASS_EN defined, a source or destination hazard is masked when wb_valid & wb_reg equals that register in the same cycle (the writeback is forwarded). full_haz is also masked when that writeback frees a slot.
REQ-038 Without SCOREBOARD_WB_BYPASS_EN, no masking occurs; the dependent instruction stalls until the cycle after the clearing edge.

Verification
REQ-039 Reset, then issue writes_d reg_D=5; next cycle decode with uses_s1 reg_S1=5 -> stall=1, pending[5]=1, outstanding=1.
REQ-040 With pending[5]=1, drive wb_valid wb_reg=5 while the dependent instruction waits:
- with bypass: stall=0 and issue=1 in the same cycle;
- without bypass: stall=1 that cycle, and issue=1 the next cycle.
REQ-041 Issue writes to regs 1,2,3,4 with MAX_OUTSTANDING=4, then decode a write to reg 6 -> stall=1 and outstanding=4; wb_reg=1 frees a slot -> issue follows per REQ-037/038.
REQ-042 Same cycle: issue write reg 7 and wb_valid wb_reg=7 with pending[7]=1 -> pending[7] stays 1, outstanding unchanged, wb_err=0.
REQ-043 wb_valid wb_reg=9 with pending[9]=0 -> wb_err=1 and stays 1; reg_D=0 writes and wb_reg=0 leave all state unchanged.
REQ-044 Hold a hazard for 70000 cycles -> stall_cycles=16'hFFFF; flush during the hazard -> stall=0, issue=0, no pending change.

Source files
------------

// File: rtl/decode_scoreboard.sv
// Register scoreboard for the decode stage: tracks outstanding register writes and stalls dependent instructions.
// Optional same-cycle writeback forwarding is enabled by defining SCOREBOARD_WB_BYPASS_EN.
module decode_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic [4:0]  reg_S1,
  input  logic [4:0]  reg_S2,
  input  logic [4:0]  reg_D,
  input  logic        uses_s1,
  input  logic        uses_s2,
  input  logic        writes_d,
  input  logic        flush,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  output logic        stall,
  output logic        issue,
  output logic [31:0] pending,
  output logic [4:0]  outstanding,
  output logic        wb_err,
  output logic [15:0] stall_cycles
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned NREGS = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [REG_W-1:0] MAX_CNT = REG_W'(MAX_OUTSTANDING);

  logic [NREGS-1:0] pend_eff;
  logic [REG_W-1:0] outst_eff;
  logic             wb_hit_c;
  logic             bad_wb_c;
  logic             set_c;
  logic             fwd_s1;
  logic             fwd_s2;
  logic             fwd_d;
  logic             fwd_slot;
  logic             src1_haz;
  logic             src2_haz;
  logic             waw_haz;
  logic             full_haz;
  logic [NREGS-1:0] pending_next;
  logic [REG_W-1:0] outstanding_next;

  // Hazard checks see the cleared state while reset is asserted.
  assign pend_eff  = reset ? '0 : pending;
  assign outst_eff = reset ? '0 : outstanding;

  assign wb_hit_c = wb_valid & (wb_reg != '0) & pending[wb_reg];
  assign bad_wb_c = wb_valid & (wb_reg != '0) & ~pending[wb_reg];

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign fwd_s1   = wb_valid & (wb_reg == reg_S1);
  assign fwd_s2   = wb_valid & (wb_reg == reg_S2);
  assign fwd_d    = wb_valid & (wb_reg == reg_D);
  assign fwd_slot = wb_valid & (wb_reg != '0) & pend_eff[wb_reg];
`else
  assign fwd_s1   = 1'b0;
  assign fwd_s2   = 1'b0;
  assign fwd_d    = 1'b0;
  assign fwd_slot = 1'b0;
`endif

  assign src1_haz = uses_s1 & (reg_S1 != '0) & pend_eff[reg_S1] & ~fwd_s1;
  assign src2_haz = uses_s2 & (reg_S2 != '0) & pend_eff[reg_S2] & ~fwd_s2;
  assign waw_haz  = writes_d & (reg_D != '0) & pend_eff[reg_D] & ~fwd_d;
  assign full_haz = writes_d & (reg_D != '0) & (outst_eff == MAX_CNT) & ~fwd_slot;

  assign stall = dec_valid & ~flush & (src1_haz | src2_haz | waw_haz | full_haz);
  assign issue = dec_valid & ~flush & ~stall;
  assign set_c = issue & writes_d & (reg_D != '0);

  // Clear first, then set, so a new writer to the retiring register keeps the bit.
  always_comb begin
    pending_next = pending;
    if (wb_hit_c) begin
      pending_next[wb_reg] = 1'b0;
    end
    if (set_c) begin
      pending_next[reg_D] = 1'b1;
    end
  end

  assign outstanding_next = outstanding + REG_W'(set_c) - REG_W'(wb_hit_c);

  always_ff @(posedge clock) begin
    if (reset) begin
      pending      <= '0;
      outstanding  <= '0;
      wb_err       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      pending     <= pending_next;
      outstanding <= outstanding_next;
      if (bad_wb_c) begin
        wb_err <= 1'b1;
      end
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: directed scenarios plus randomized traffic against a reference model.
module tb_decode_scoreboard;

  localparam int MAXO = 4;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  reg_S1;
  logic [4:0]  reg_S2;
  logic [4:0]  reg_D;
  logic        uses_s1;
  logic        uses_s2;
  logic        writes_d;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        stall;
  logic        issue;
  logic [31:0] pending;
  logic [4:0]  outstanding;
  logic        wb_err;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  bit m_pend [32];
  bit m_err;
  int m_sc;

  decode_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset), .dec_valid(dec_valid),
    .reg_S1(reg_S1), .reg_S2(reg_S2), .reg_D(reg_D),
    .uses_s1(uses_s1), .uses_s2(uses_s2), .writes_d(writes_d),
    .flush(flush), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .stall(stall), .issue(issue), .pending(pending),
    .outstanding(outstanding), .wb_err(wb_err), .stall_cycles(stall_cycles)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic drive(input logic v, input logic u1, input logic [4:0] s1,
                       input logic u2, input logic [4:0] s2,
                       input logic wd, input logic [4:0] d, input logic fl,
                       input logic wv, input logic [4:0] wr);
    dec_valid = v; uses_s1 = u1; reg_S1 = s1; uses_s2 = u2; reg_S2 = s2;
    writes_d = wd; reg_D = d; flush = fl; wb_valid = wv; wb_reg = wr;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL reset_issue got=%b exp=1", issue); end
    tick();
    tick();
    reset = 1'b0;
    idle();
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
    checks++; if (outstanding !== 5'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_raw_hazard();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL raw_first_issue got=%b exp=1", issue); end
    tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%b exp=1", stall); end
    checks++; if (pending !== 32'h20) begin failures++; $display("FAIL raw_pending got=%h exp=20", pending); end
    checks++; if (outstanding !== 5'd1) begin failures++; $display("FAIL raw_outstanding got=%0d exp=1", outstanding); end
    tick();
    checks++; if (stall_cycles !== 16'd1) begin failures++; $display("FAIL raw_stall_cycles got=%0d exp=1", stall_cycles); end
    drive(1, 1, 5, 0, 0, 0, 0, 0, 1, 5);
    checks++; if (stall !== !BYP) begin failures++; $display("FAIL raw_wb_stall got=%b exp=%b", stall, !BYP); end
    checks++; if (issue !== BYP) begin failures++; $display("FAIL raw_wb_issue got=%b exp=%b", issue, BYP); end
    tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL raw_cleared got=%h exp=0", pending); end
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL raw_after_issue got=%b exp=1", issue); end
    tick();
  endtask

  task automatic test_full();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      drive(1, 0, 0, 0, 0, 1, 5'(r), 0, 0, 0);
      checks++; if (issue !== 1'b1) begin failures++; $display("FAIL full_fill_issue r=%0d got=%b exp=1", r, issue); end
      tick();
    end
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_stall got=%b exp=1", stall); end
    checks++; if (outstanding !== 5'd4) begin failures++; $display("FAIL full_outstanding got=%0d exp=4", outstanding); end
    tick();
    drive(1, 0, 0, 0, 0, 1, 6, 0, 1, 1);
    checks++; if (issue !== BYP) begin failures++; $display("FAIL full_wb_issue got=%b exp=%b", issue, BYP); end
    tick();
    // Bypass build has already issued reg 6, so this retry hits a WAW stall instead.
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    checks++; if (issue !== !BYP) begin failures++; $display("FAIL full_retry_issue got=%b exp=%b", issue, !BYP); end
    tick();
    idle();
    checks++; if (pending !== 32'h5C) begin failures++; $display("FAIL full_pending got=%h exp=5c", pending); end
    checks++; if (outstanding !== 5'd4) begin failures++; $display("FAIL full_final_outstanding got=%0d exp=4", outstanding); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 8, 0, 1, 7);
    tick();
    idle();
    checks++; if (pending !== 32'h100) begin failures++; $display("FAIL diff_reg_pending got=%h exp=100", pending); end
    checks++; if (outstanding !== 5'd1) begin failures++; $display("FAIL diff_reg_outstanding got=%0d exp=1", outstanding); end
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 1, 7);
    checks++; if (issue !== BYP) begin failures++; $display("FAIL same_reg_issue got=%b exp=%b", issue, BYP); end
    tick();
    idle();
    checks++; if (pending !== (BYP ? 32'h180 : 32'h100)) begin failures++; $display("FAIL same_reg_pending got=%h", pending); end
    checks++; if (outstanding !== (BYP ? 5'd2 : 5'd1)) begin failures++; $display("FAIL same_reg_outstanding got=%0d", outstanding); end
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL same_reg_wb_err got=%b exp=0", wb_err); end
  endtask

  task automatic test_wb_err();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    tick();
    idle();
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL wb_err_set got=%b exp=1", wb_err); end
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL wb_err_pending got=%h exp=0", pending); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL wb_err_sticky got=%b exp=1", wb_err); end
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0, 1, 0, 0, 1, 0);
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL reg0_issue got=%b exp=1", issue); end
    tick();
    idle();
    checks++; if (pending !== 32'h8) begin failures++; $display("FAIL reg0_pending got=%h exp=8", pending); end
    checks++; if (outstanding !== 5'd1) begin failures++; $display("FAIL reg0_outstanding got=%0d exp=1", outstanding); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_stall got=%b exp=1", stall); end
    for (int i = 0; i < 70000; i++) tick();
    checks++; if (stall_cycles !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h exp=ffff", stall_cycles); end
    drive(1, 1, 5, 0, 0, 1, 10, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    checks++; if (issue !== 1'b0) begin failures++; $display("FAIL flush_issue got=%b exp=0", issue); end
    tick();
    idle();
    checks++; if (pending !== 32'h20) begin failures++; $display("FAIL flush_pending got=%h exp=20", pending); end
    checks++; if (stall_cycles !== 16'hFFFF) begin failures++; $display("FAIL flush_count got=%h exp=ffff", stall_cycles); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%b exp=0", stall); end
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL midrst_issue got=%b exp=1", issue); end
    tick();
    reset = 1'b0;
    idle();
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL midrst_pending got=%h exp=0", pending); end
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", stall_cycles); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    tick();
    idle();
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL midrst_wb_err got=%b exp=1", wb_err); end
  endtask

  task automatic test_random();
    bit r, v, u1, u2, wd, fl, wv, e_stall, e_issue, full, h1, h2, hd;
    logic [4:0] s1, s2, d, wr;
    do_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_err = 1'b0;
    m_sc = 0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) < 2);
      v  = ($urandom_range(0, 99) < 80);
      u1 = $urandom_range(0, 1);
      u2 = $urandom_range(0, 1);
      wd = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 10);
      wv = ($urandom_range(0, 99) < 35);
      s1 = 5'($urandom_range(0, 7));
      s2 = 5'($urandom_range(0, 7));
      d  = 5'($urandom_range(0, 9));
      wr = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      reset = r;
      drive(v, u1, s1, u2, s2, wd, d, fl, wv, wr);
      h1 = !r && s1 != 0 && m_pend[s1] && !(BYP && wv && wr == s1);
      h2 = !r && s2 != 0 && m_pend[s2] && !(BYP && wv && wr == s2);
      hd = !r && d != 0 && m_pend[d] && !(BYP && wv && wr == d);
      full = !r && wd && d != 0 && m_count() == MAXO && !(BYP && wv && wr != 0 && m_pend[wr]);
      e_stall = v && !fl && ((u1 && h1) || (u2 && h2) || (wd && hd) || full);
      e_issue = v && !fl && !e_stall;
      checks++; if (stall !== e_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, e_stall); end
      checks++; if (issue !== e_issue) begin failures++; $display("FAIL rnd_issue n=%0d got=%b exp=%b", n, issue, e_issue); end
      if (r) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_err = 1'b0;
        m_sc = 0;
      end else begin
        if (wv && wr != 0) begin
          if (m_pend[wr]) m_pend[wr] = 1'b0;
          else m_err = 1'b1;
        end
        if (e_issue && wd && d != 0) m_pend[d] = 1'b1;
        if (e_stall && m_sc < 65535) m_sc++;
      end
      tick();
      checks++; if (pending !== m_vec()) begin failures++; $display("FAIL rnd_pending n=%0d got=%h exp=%h", n, pending, m_vec()); end
      checks++; if (outstanding !== 5'(m_count())) begin failures++; $display("FAIL rnd_outstanding n=%0d got=%0d exp=%0d", n, outstanding, m_count()); end
      checks++; if (wb_err !== m_err) begin failures++; $display("FAIL rnd_wb_err n=%0d got=%b exp=%b", n, wb_err, m_err); end
      checks++; if (stall_cycles !== 16'(m_sc)) begin failures++; $display("FAIL rnd_stall_cycles n=%0d got=%0d exp=%0d", n, stall_cycles, m_sc); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_raw_hazard();
    test_full();
    test_same_cycle();
    test_wb_err();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
